// File: rtl/lint_wide_to_narrow_split.sv
// Splits one wide LINT master port into NB_LANES independent 32-bit LINT slave ports and
// reassembles the per-lane responses, in grant order, into one wide response.
module lint_w2n_lane #(
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        wide_req,
    input  logic        full,
    input  logic        wide_gnt,
    input  logic        gnt_i,
    input  logic        r_valid_i,
    input  logic [31:0] r_rdata_i,
    input  logic        pop,
    output logic        req_o,
    output logic        granted,
    output logic        rsp_vld,
    output logic [31:0] rsp_data
);
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic          gnt_q;
    logic [CW-1:0] owed, cnt;
    logic [PW-1:0] wptr, rptr;
    logic [31:0]   mem [MAX_OUTST];
    logic          hs, accept;

    assign req_o    = wide_req & sel & ~gnt_q & ~full;
    assign granted  = gnt_q | gnt_i;
    assign hs       = req_o & gnt_i;
    // owed counts lane handshakes still waiting for data; a response beyond that is spurious
    assign accept   = r_valid_i & (owed != '0);
    assign rsp_vld  = (cnt != '0);
    assign rsp_data = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q <= 1'b0;
            owed  <= '0;
            cnt   <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (wide_gnt)
                gnt_q <= 1'b0;
            else if (hs)
                gnt_q <= 1'b1;
            owed <= owed + CW'(hs) - CW'(accept);
            cnt  <= cnt + CW'(accept) - CW'(pop);
            if (accept)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr] <= r_rdata_i;
    end

    a_spurious: assert property (@(posedge clk) disable iff (!rst_n) r_valid_i |-> owed != '0);
endmodule

module lint_wide_to_narrow_split #(
    parameter int NB_LANES  = 2,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       data_req_i,
    output logic                       data_gnt_o,
    input  logic [ADDR_W-1:0]          data_add_i,
    input  logic                       data_wen_i,
    input  logic [32*NB_LANES-1:0]     data_wdata_i,
    input  logic [4*NB_LANES-1:0]      data_be_i,
    input  logic                       data_size_i,
    output logic                       data_r_valid_o,
    output logic [32*NB_LANES-1:0]     data_r_rdata_o,
    output logic [NB_LANES-1:0]        data_req_o,
    input  logic [NB_LANES-1:0]        data_gnt_i,
    output logic [NB_LANES*ADDR_W-1:0] data_add_o,
    output logic [NB_LANES-1:0]        data_wen_o,
    output logic [32*NB_LANES-1:0]     data_wdata_o,
    output logic [4*NB_LANES-1:0]      data_be_o,
    input  logic [NB_LANES-1:0]        data_r_valid_i,
    input  logic [32*NB_LANES-1:0]     data_r_rdata_i
);
    localparam int SW  = $clog2(NB_LANES);
    localparam int LSB = SW + 2;
    localparam int PW  = $clog2(MAX_OUTST);
    localparam int CW  = $clog2(MAX_OUTST + 1);

    logic [SW-1:0]             sel;
    logic [NB_LANES-1:0]       mask, granted, rsp_vld, pop, head_m;
    logic [NB_LANES-1:0][31:0] rsp_data;
    logic [ADDR_W-1:0]         base;
    logic                      full, complete;
    logic [CW-1:0]             pcnt;
    logic [PW-1:0]             pwptr, prptr;
    // The lane mask alone identifies the access type, so size is not stored separately
    logic [NB_LANES-1:0]       pmem [MAX_OUTST];

    assign sel  = data_add_i[LSB-1:2];
    assign mask = data_size_i ? {NB_LANES{1'b1}} : (NB_LANES'(1) << sel);
    assign base = {data_add_i[ADDR_W-1:LSB], LSB'(0)};
    assign full = (pcnt == CW'(MAX_OUTST));

    assign data_gnt_o     = data_req_i & ~full & ((granted & mask) == mask);
    assign head_m         = pmem[prptr];
    assign complete       = (pcnt != '0) & ((rsp_vld & head_m) == head_m);
    assign pop            = {NB_LANES{complete}} & head_m;
    assign data_r_valid_o = complete;
    assign data_wen_o     = {NB_LANES{data_wen_i}};
    assign data_wdata_o   = data_wdata_i;
    assign data_be_o      = data_be_i;

    for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
        lint_w2n_lane #(.MAX_OUTST(MAX_OUTST)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .sel       (mask[k]),
            .wide_req  (data_req_i),
            .full      (full),
            .wide_gnt  (data_gnt_o),
            .gnt_i     (data_gnt_i[k]),
            .r_valid_i (data_r_valid_i[k]),
            .r_rdata_i (data_r_rdata_i[32*k +: 32]),
            .pop       (pop[k]),
            .req_o     (data_req_o[k]),
            .granted   (granted[k]),
            .rsp_vld   (rsp_vld[k]),
            .rsp_data  (rsp_data[k])
        );
        assign data_add_o[ADDR_W*k +: ADDR_W] = data_size_i ? base + ADDR_W'(4 * k) : data_add_i;
        assign data_r_rdata_o[32*k +: 32]     = pop[k] ? rsp_data[k] : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= '0;
            pwptr <= '0;
            prptr <= '0;
        end else begin
            pcnt <= pcnt + CW'(data_gnt_o) - CW'(complete);
            if (data_gnt_o)
                pwptr <= pwptr + PW'(1);
            if (complete)
                prptr <= prptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (data_gnt_o)
            pmem[pwptr] <= mask;
    end

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        data_req_i && !data_gnt_o |=> data_req_i && $stable(data_add_i) && $stable(data_size_i)
            && $stable(data_wen_i) && $stable(data_wdata_i) && $stable(data_be_i));
endmodule

// File: tb/tb_lint_wide_to_narrow_split.sv
// Bench for lint_wide_to_narrow_split: directed literal cases, then randomized traffic
// against a queue-based model of lanes, outstanding transactions and delivered responses.
module tb_lint_wide_to_narrow_split;
    localparam int L = 2, AW = 32, MO = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic req, gnt, wen, size, r_valid;
    logic [AW-1:0]   add;
    logic [32*L-1:0] wdata, r_rdata, wdata_o, rdata_i;
    logic [4*L-1:0]  be, be_o;
    logic [L-1:0]    req_o, gnt_i, wen_o, rv_i;
    logic [L*AW-1:0] add_o;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    lint_wide_to_narrow_split #(.NB_LANES(L), .ADDR_W(AW), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req), .data_gnt_o(gnt), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_size_i(size),
        .data_r_valid_o(r_valid), .data_r_rdata_o(r_rdata),
        .data_req_o(req_o), .data_gnt_i(gnt_i), .data_add_o(add_o), .data_wen_o(wen_o),
        .data_wdata_o(wdata_o), .data_be_o(be_o),
        .data_r_valid_i(rv_i), .data_r_rdata_i(rdata_i)
    );

    // model state
    logic [L-1:0] exp_q [$];
    logic [31:0]  lane_rx [L][$];
    logic [31:0]  slv_dat [L][$];
    int           slv_due [L][$];
    logic         m_act;
    logic [L-1:0] m_mask, m_done;
    int           cyc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        req = 0; size = 0; wen = 1; add = '0; wdata = '0; be = '0;
        gnt_i = '0; rv_i = '0; rdata_i = '0;
    endtask

    task automatic wreq(input logic [31:0] a, input logic s);
        req = 1; add = a; size = s; wen = 1; be = '1;
        for (int k = 0; k < L; k++) wdata[32*k +: 32] = $urandom;
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int k = 0; k < L; k++) begin
            lane_rx[k].delete(); slv_dat[k].delete(); slv_due[k].delete();
        end
        m_act = 0; m_mask = '0; m_done = '0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_gnt"}, gnt, 0);
        chk({name, "_rvalid"}, r_valid, 0);
        chk({name, "_req_o"}, req_o, 0);
        chk({name, "_rdata"}, r_rdata, 0);
    endtask

    task automatic rand_cycle(input bit allow_new);
        logic full, egnt, comp;
        logic [L-1:0] ereq, hm;
        logic [32*L-1:0] erd;
        logic [AW*L-1:0] eadd;
        int s;
        tick();
        if (!m_act && allow_new && $urandom_range(3) != 0) begin
            m_act = 1; add = $urandom; size = 1'($urandom_range(1)); wen = 1'($urandom_range(1));
            be = L*4'($urandom);
            for (int k = 0; k < L; k++) wdata[32*k +: 32] = $urandom;
            s = int'((add >> 2) % L);
            m_mask = size ? '1 : (L'(1) << s);
            m_done = '0;
        end
        req = m_act;
        for (int k = 0; k < L; k++) begin
            gnt_i[k] = ($urandom_range(2) != 0);
            rv_i[k]  = (slv_due[k].size() != 0) && (slv_due[k][0] <= cyc) && ($urandom_range(3) != 0);
            rdata_i[32*k +: 32] = rv_i[k] ? slv_dat[k][0] : $urandom;
        end
        mid();
        full = (exp_q.size() == MO);
        ereq = (m_act && !full) ? (m_mask & ~m_done) : '0;
        egnt = m_act && !full && (((m_done | gnt_i) & m_mask) == m_mask);
        comp = 0; hm = '0; erd = '0;
        if (exp_q.size() != 0) begin
            hm = exp_q[0]; comp = 1;
            for (int k = 0; k < L; k++) if (hm[k] && lane_rx[k].size() == 0) comp = 0;
        end
        if (comp) for (int k = 0; k < L; k++) if (hm[k]) erd[32*k +: 32] = lane_rx[k][0];
        chk("rnd_req_o", req_o, ereq);
        chk("rnd_gnt_o", gnt, egnt);
        chk("rnd_r_valid_o", r_valid, comp);
        chk("rnd_r_rdata_o", r_rdata, erd);
        if (m_act) begin
            for (int k = 0; k < L; k++)
                eadd[AW*k +: AW] = size ? AW'((add / (4*L)) * (4*L) + 4*k) : add;
            chk("rnd_add_o", add_o, eadd);
            chk("rnd_wen_be_wdata_o", {wen_o, be_o, wdata_o}, {{L{wen}}, be, wdata});
        end
        if (comp) begin
            void'(exp_q.pop_front());
            for (int k = 0; k < L; k++) if (hm[k]) void'(lane_rx[k].pop_front());
        end
        for (int k = 0; k < L; k++) begin
            if (rv_i[k]) begin
                lane_rx[k].push_back(slv_dat[k].pop_front());
                void'(slv_due[k].pop_front());
            end
            if (ereq[k] && gnt_i[k]) begin
                slv_due[k].push_back(cyc + 1 + int'($urandom_range(4)));
                slv_dat[k].push_back($urandom);
                m_done[k] = 1;
            end
        end
        if (egnt) begin
            exp_q.push_back(m_mask);
            m_act = 0;
        end
        cyc++;
    endtask

    initial begin
        logic [63:0] e;
        idle(); rst_n = 0; cyc = 0; model_clear();
        repeat (2) @(posedge clk);
        mid(); chk_quiet("reset");
        tick(); rst_n = 1;

        // full-width access, both lanes grant together, responses two cycles later
        tick(); wreq(32'h1000, 1); gnt_i = 2'b11;
        mid(); chk("t1_gnt", gnt, 1); chk("t1_req_o", req_o, 2'b11);
        chk("t1_add_o", add_o, 64'h00001004_00001000);
        tick(); idle();
        tick(); rv_i = 2'b11; rdata_i = 64'hAAAA0001_55550000;
        mid(); chk("t1_rvalid_early", r_valid, 0);
        tick(); rv_i = 2'b00;
        mid(); chk("t1_rvalid", r_valid, 1); chk("t1_rdata", r_rdata, 64'hAAAA0001_55550000);
        tick(); mid(); chk("t1_rvalid_after", r_valid, 0);

        // lanes grant on different cycles
        tick(); wreq(32'h3000, 1); gnt_i = 2'b01;
        mid(); chk("t2_req0", req_o, 2'b11); chk("t2_gnt0", gnt, 0);
        tick(); gnt_i = 2'b00;
        mid(); chk("t2_req1", req_o, 2'b10); chk("t2_gnt1", gnt, 0);
        tick(); gnt_i = 2'b10;
        mid(); chk("t2_req2", req_o, 2'b10); chk("t2_gnt2", gnt, 1);
        tick(); idle();
        tick(); rv_i = 2'b11; rdata_i = 64'h22220002_11110001;
        tick(); rv_i = 2'b00;
        mid(); chk("t2_rvalid", r_valid, 1); chk("t2_rdata", r_rdata, 64'h22220002_11110001);

        // single-lane access to lane 1
        tick(); wreq(32'h2004, 0); gnt_i = 2'b10;
        mid(); chk("t3_req_o", req_o, 2'b10); chk("t3_gnt", gnt, 1);
        chk("t3_add1", add_o[AW +: AW], 32'h2004);
        tick(); idle();
        tick(); rv_i = 2'b10; rdata_i = 64'hCAFE0001_12345678;
        tick(); rv_i = 2'b00;
        mid(); chk("t3_rvalid", r_valid, 1); chk("t3_rdata", r_rdata, 64'hCAFE0001_00000000);

        // fill to MAX_OUTST, fifth request held off until the first completion
        for (int i = 0; i < 4; i++) begin
            tick(); wreq(32'h4000 + 32'(i*8), 1); gnt_i = 2'b11;
            mid(); chk("t4_gnt_fill", gnt, 1);
        end
        tick(); wreq(32'h5000, 1);
        mid(); chk("t4_full_req", req_o, 2'b00); chk("t4_full_gnt", gnt, 0);
        tick(); rv_i = 2'b11; rdata_i = 64'hB0000000_A0000000;
        mid(); chk("t4_full_req2", req_o, 2'b00);
        tick(); rv_i = 2'b00;
        mid(); chk("t4_first_rvalid", r_valid, 1); chk("t4_still_full", req_o, 2'b00);
        tick();
        mid(); chk("t4_req_resume", req_o, 2'b11); chk("t4_gnt_resume", gnt, 1);
        tick(); req = 0; gnt_i = 2'b00;
        for (int j = 0; j < 4; j++) begin
            rv_i = 2'b11; rdata_i = {32'hB0000001 + 32'(j), 32'hA0000001 + 32'(j)};
            mid(); chk("t4_drain_rvalid", r_valid, j > 0);
            if (j > 0) begin
                e = {32'hB0000000 + 32'(j), 32'hA0000000 + 32'(j)};
                chk("t4_drain_rdata", r_rdata, e);
            end
            tick();
        end
        rv_i = 2'b00;
        mid(); chk("t4_last_rvalid", r_valid, 1); chk("t4_last_rdata", r_rdata, 64'hB0000004_A0000004);
        tick(); mid(); chk("t4_idle", r_valid, 0);

        // lane 1 answers A and B before lane 0 answers A
        tick(); wreq(32'h8000, 1); gnt_i = 2'b11;
        mid(); chk("t5_gntA", gnt, 1);
        tick(); wreq(32'h8008, 1); gnt_i = 2'b11;
        mid(); chk("t5_gntB", gnt, 1);
        tick(); idle(); rv_i = 2'b10; rdata_i = 64'hA1A1A1A1_00000000;
        tick(); rv_i = 2'b10; rdata_i = 64'hB1B1B1B1_00000000;
        mid(); chk("t5_wait1", r_valid, 0);
        tick(); rv_i = 2'b01; rdata_i = 64'h00000000_A0A0A0A0;
        mid(); chk("t5_wait2", r_valid, 0);
        tick(); rv_i = 2'b01; rdata_i = 64'h00000000_B0B0B0B0;
        mid(); chk("t5_rvA", r_valid, 1); chk("t5_rdA", r_rdata, 64'hA1A1A1A1_A0A0A0A0);
        tick(); rv_i = 2'b00;
        mid(); chk("t5_rvB", r_valid, 1); chk("t5_rdB", r_rdata, 64'hB1B1B1B1_B0B0B0B0);
        tick(); mid(); chk("t5_idle", r_valid, 0);

        // reset with three outstanding, narrow responses arriving during reset
        for (int i = 0; i < 3; i++) begin
            tick(); wreq(32'h6000 + 32'(i*8), 1); gnt_i = 2'b11;
            mid(); chk("t6_gnt", gnt, 1);
        end
        tick(); idle(); rst_n = 0; rv_i = 2'b11; rdata_i = 64'hDEADDEAD_DEADDEAD;
        mid(); chk_quiet("t6_in_reset");
        tick(); rv_i = 2'b00;
        tick(); rst_n = 1;
        mid(); chk("t6_no_rvalid", r_valid, 0);
        tick(); mid(); chk("t6_no_rvalid2", r_valid, 0);
        tick(); wreq(32'h7000, 1); gnt_i = 2'b11;
        mid(); chk("t6_gnt_after", gnt, 1); chk("t6_req_after", req_o, 2'b11);
        tick(); idle();
        tick(); rv_i = 2'b11; rdata_i = 64'h77770001_77770000;
        tick(); rv_i = 2'b00;
        mid(); chk("t6_rvalid_after", r_valid, 1); chk("t6_rdata_after", r_rdata, 64'h77770001_77770000);
        tick(); mid(); chk("t6_idle", r_valid, 0);

        // randomized traffic with a mid-run reset
        model_clear();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                tick(); idle(); rst_n = 0; rv_i = '1;
                mid(); chk_quiet("rnd_reset");
                tick(); rv_i = '0;
                tick(); rst_n = 1;
                model_clear();
            end
            rand_cycle(1'b1);
        end
        for (int i = 0; i < 300 && (m_act || exp_q.size() != 0); i++) rand_cycle(1'b0);
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_req_granted", m_act, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
